ahb_sram_arbiter: RTL and testbench
===================================

// Module: ahb_sram_arbiter
// PURPOSE
//  Two-master AHB arbiter and bus multiplexer in front of the single AHB SRAM slave (base 0x0010_0000).
//  Grants the shared slave round-robin, holds the grant for locked transfers and defined-length bursts,
//  and caps undefined-length INCR bursts for fairness.
//  Routes the owning master's address/control (address phase) and HWDATA (data phase) to the slave;
//  broadcasts HRDATA/HREADY/HRESP to both masters.
// PARAMETERS
//  MAX_INCR_BEATS  16  max beats of an undefined-length INCR burst before forced re-arbitration (range 2..255)
// PORTS
//  HCLK            in   1   system clock
//  HRESET          in   1   synchronous, active-high reset
//  m0_HBUSREQ      in   1   master 0 bus request (m1_* identical for master 1)
//  m0_HLOCK        in   1   master 0 locked-transfer request
//  m0_HTRANS       in   2   master 0 transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11)
//  m0_HADDR        in   32  master 0 address
//  m0_HWRITE/HSIZE/HBURST  in  1/3/3  master 0 control
//  m0_HWDATA       in   32  master 0 write data
//  m0_HGRANT       out  1   grant to master 0 (m1_HGRANT for master 1)
//  HMASTER         out  1   address-phase owner index
//  HMASTLOCK       out  1   current address phase is locked
//  s_HADDR/HTRANS/HWRITE/HSIZE/HBURST/HWDATA  out  32/2/1/3/3/32  to slave
//  s_HRDATA        in   32  from slave
//  s_HREADY        in   1   from slave
//  s_HRESP         in   1   from slave
//  HRDATA          out  32  to both masters
//  HREADY          out  1   to both masters
//  HRESP           out  1   to both masters
// BEHAVIOUR
//  - Reset values: m0_HGRANT=1 (default/park master 0), m1_HGRANT=0, HMASTER=0, HMASTLOCK=0, data owner=0,
//    beat counter=0, rr pointer=1 (master 1 next priority).
//  - All state updates only on a rising HCLK edge with HREADY=1; with HREADY=0 everything holds.
//    HRESET overrides HREADY.
//  - On each HREADY=1 edge (pipeline): data_owner<=HMASTER; HMASTER<=granted index;
//    HMASTLOCK<=granted HLOCK; HGRANT<=new arbitration result.
//  - Latency: request seen at edge N -> HGRANT at N+1 -> HMASTER switches at the next HREADY=1 edge.
//  - Address mux (combinational): s_HADDR/HTRANS/HWRITE/HSIZE/HBURST from master HMASTER.
//    s_HWDATA from data_owner.
//  - HRDATA=s_HRDATA, HREADY=s_HREADY, HRESP=s_HRESP, passed straight through.
//  - Grant FSM states: OWN0, OWN1 (state equals the currently granted master).
//  - Hold conditions; grant is kept when any of these is true:
//    (a) owner HLOCK=1 and HBUSREQ=1;
//    (b) fixed-length burst in progress: beat counter>0
//        (loaded on NONSEQ with 3/7/15 for WRAP4/INCR4, WRAP8/INCR8, WRAP16/INCR16);
//        decremented per SEQ beat; BUSY does not decrement;
//    (c) INCR (HBURST=001) with HTRANS SEQ/BUSY and incr_cnt<MAX_INCR_BEATS-1.
//  - Otherwise re-arbitrate round-robin. The requester pointed to by rr wins if requesting, else the other.
//    If neither requests, the grant stays (park) on the current owner.
//    rr flips to the non-winner whenever the grant changes.
//  - incr_cnt: cleared on NONSEQ, incremented per SEQ beat, saturates. The forced switch occurs only if the
//    other master requests; the pre-empted master restarts with NONSEQ (AHB early termination).
//  - Simultaneous requests out of reset: master 1 wins (rr=1).
//  - Owner drops HBUSREQ mid fixed burst: the burst still completes before switching.
//  - Reset mid-transfer: all state returns to reset values next edge; the in-flight slave transfer is abandoned.
// TESTING
//  - Reset: assert HRESET 2 cycles -> m0_HGRANT=1, m1_HGRANT=0, HMASTER=0, s_HTRANS=m0_HTRANS.
//  - Single master: m1 requests, NONSEQ write 0x0010_0010 data 0xA5A5_0001 ->
//    m1_HGRANT after 1 cycle, HMASTER=1 next edge; SRAM word 4 = 0xA5A5_0001; s_HWDATA from m1 in data phase.
//  - Contention: both request from reset -> m1 granted first; after its single transfer and m1 idle ->
//    m0 granted; rr alternates on repeated contention.
//  - INCR4 burst by m0 with m1 requesting -> HMASTER stays 0 for all 4 beats;
//    m1_HGRANT asserts on the edge of the last beat.
//  - Locked: m0 HLOCK=1 for 6 transfers, m1 requesting -> no grant change until HLOCK drops;
//    HMASTLOCK=1 throughout.
//  - Wait states: slave holds s_HREADY=0 for 3 cycles during m1 read of 0x0010_0008 ->
//    HMASTER, grants and s_HWDATA source frozen; HRDATA = stored word when HREADY returns.
//  - INCR fairness: m0 undefined INCR of 40 beats, m1 requesting, MAX_INCR_BEATS=16 ->
//    grant moves to m1 after beat 16.

Source files
------------

// File: rtl/ahb_sram_arbiter_if.sv
// Two AHB masters, the shared SRAM slave and the arbiter status outputs on one bundle.
// The slave modport is the arbiter's view. The master modport is the surrounding masters and SRAM.
interface ahb_sram_arbiter_if;
    logic        m0_HBUSREQ;
    logic        m0_HLOCK;
    logic [1:0]  m0_HTRANS;
    logic [31:0] m0_HADDR;
    logic        m0_HWRITE;
    logic [2:0]  m0_HSIZE;
    logic [2:0]  m0_HBURST;
    logic [31:0] m0_HWDATA;
    logic        m0_HGRANT;

    logic        m1_HBUSREQ;
    logic        m1_HLOCK;
    logic [1:0]  m1_HTRANS;
    logic [31:0] m1_HADDR;
    logic        m1_HWRITE;
    logic [2:0]  m1_HSIZE;
    logic [2:0]  m1_HBURST;
    logic [31:0] m1_HWDATA;
    logic        m1_HGRANT;

    logic        HMASTER;
    logic        HMASTLOCK;

    logic [31:0] s_HADDR;
    logic [1:0]  s_HTRANS;
    logic        s_HWRITE;
    logic [2:0]  s_HSIZE;
    logic [2:0]  s_HBURST;
    logic [31:0] s_HWDATA;
    logic [31:0] s_HRDATA;
    logic        s_HREADY;
    logic        s_HRESP;

    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport slave (
        input  m0_HBUSREQ, m0_HLOCK, m0_HTRANS, m0_HADDR, m0_HWRITE, m0_HSIZE, m0_HBURST, m0_HWDATA,
        input  m1_HBUSREQ, m1_HLOCK, m1_HTRANS, m1_HADDR, m1_HWRITE, m1_HSIZE, m1_HBURST, m1_HWDATA,
        output m0_HGRANT, m1_HGRANT, HMASTER, HMASTLOCK,
        output s_HADDR, s_HTRANS, s_HWRITE, s_HSIZE, s_HBURST, s_HWDATA,
        input  s_HRDATA, s_HREADY, s_HRESP,
        output HRDATA, HREADY, HRESP
    );

    modport master (
        output m0_HBUSREQ, m0_HLOCK, m0_HTRANS, m0_HADDR, m0_HWRITE, m0_HSIZE, m0_HBURST, m0_HWDATA,
        output m1_HBUSREQ, m1_HLOCK, m1_HTRANS, m1_HADDR, m1_HWRITE, m1_HSIZE, m1_HBURST, m1_HWDATA,
        input  m0_HGRANT, m1_HGRANT, HMASTER, HMASTLOCK,
        input  s_HADDR, s_HTRANS, s_HWRITE, s_HSIZE, s_HBURST, s_HWDATA,
        output s_HRDATA, s_HREADY, s_HRESP,
        input  HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/ahb_sram_arbiter.sv
// Round-robin two-master AHB arbiter and mux in front of the SRAM slave, with burst, lock and INCR-cap hold.
// Latency: request at edge N -> HGRANT after N -> HMASTER after the next HREADY edge; data mux follows one phase later.
// Backpressure: every register holds while HREADY is low; read data and response are passed straight through.
module ahb_sram_arbiter #(
    parameter int MAX_INCR_BEATS = 16
) (
    input  logic              HCLK,
    input  logic              HRESET,
    ahb_sram_arbiter_if.slave bus
);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;
    localparam logic [2:0] BR_INCR   = 3'b001;
    localparam logic [7:0] INCR_LIMIT = 8'(MAX_INCR_BEATS - 1);

    typedef enum logic {OWN0 = 1'b0, OWN1 = 1'b1} own_e;

    own_e       state;
    logic       gnt0_q;
    logic       gnt1_q;
    logic       hmaster_q;
    logic       hmastlock_q;
    logic       data_owner;
    logic       rr;
    logic [3:0] beat_cnt;
    logic [7:0] incr_cnt;

    logic        cur_idx;
    logic        own_req;
    logic        own_lock;
    logic [1:0]  req_vec;
    logic [1:0]  s_trans;
    logic [2:0]  s_burst;
    logic [3:0]  beat_nxt;
    logic [7:0]  incr_nxt;
    logic        hold;
    logic        next_idx;

    assign cur_idx  = (state == OWN1);
    assign own_req  = cur_idx ? bus.m1_HBUSREQ : bus.m0_HBUSREQ;
    assign own_lock = cur_idx ? bus.m1_HLOCK   : bus.m0_HLOCK;
    assign req_vec  = {bus.m1_HBUSREQ, bus.m0_HBUSREQ};

    assign s_trans      = hmaster_q ? bus.m1_HTRANS : bus.m0_HTRANS;
    assign s_burst      = hmaster_q ? bus.m1_HBURST : bus.m0_HBURST;
    assign bus.s_HTRANS = s_trans;
    assign bus.s_HBURST = s_burst;
    assign bus.s_HADDR  = hmaster_q ? bus.m1_HADDR  : bus.m0_HADDR;
    assign bus.s_HWRITE = hmaster_q ? bus.m1_HWRITE : bus.m0_HWRITE;
    assign bus.s_HSIZE  = hmaster_q ? bus.m1_HSIZE  : bus.m0_HSIZE;
    assign bus.s_HWDATA = data_owner ? bus.m1_HWDATA : bus.m0_HWDATA;

    assign bus.HRDATA = bus.s_HRDATA;
    assign bus.HREADY = bus.s_HREADY;
    assign bus.HRESP  = bus.s_HRESP;

    assign bus.m0_HGRANT = gnt0_q;
    assign bus.m1_HGRANT = gnt1_q;
    assign bus.HMASTER   = hmaster_q;
    assign bus.HMASTLOCK = hmastlock_q;

    // Burst bookkeeping follows whatever is in the address phase on the slave side.
    always_comb begin
        beat_nxt = beat_cnt;
        incr_nxt = incr_cnt;
        case (s_trans)
            TR_NONSEQ: begin
                incr_nxt = 8'd0;
                case (s_burst)
                    3'b010, 3'b011: beat_nxt = 4'd3;
                    3'b100, 3'b101: beat_nxt = 4'd7;
                    3'b110, 3'b111: beat_nxt = 4'd15;
                    default:        beat_nxt = 4'd0;
                endcase
            end
            TR_SEQ: begin
                if (beat_cnt != 4'd0) beat_nxt = beat_cnt - 4'd1;
                if (incr_cnt != 8'hFF) incr_nxt = incr_cnt + 8'd1;
            end
            default: ;
        endcase
    end

    // A grant that has moved but not yet taken the address bus is held so the new owner gets its first phase.
    always_comb begin
        hold = (own_lock & own_req)
             | (hmaster_q != cur_idx)
             | (beat_nxt != 4'd0)
             | ((s_burst == BR_INCR) && (s_trans != TR_IDLE) && (incr_nxt < INCR_LIMIT));
        next_idx = cur_idx;
        if (!hold) begin
            if (req_vec[rr])       next_idx = rr;
            else if (req_vec[~rr]) next_idx = ~rr;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state       <= OWN0;
            gnt0_q      <= 1'b1;
            gnt1_q      <= 1'b0;
            hmaster_q   <= 1'b0;
            hmastlock_q <= 1'b0;
            data_owner  <= 1'b0;
            rr          <= 1'b1;
            beat_cnt    <= 4'd0;
            incr_cnt    <= 8'd0;
        end else if (bus.s_HREADY) begin
            data_owner  <= hmaster_q;
            hmaster_q   <= cur_idx;
            hmastlock_q <= own_lock;
            beat_cnt    <= beat_nxt;
            incr_cnt    <= incr_nxt;
            if (next_idx != cur_idx) rr <= cur_idx;
            state  <= next_idx ? OWN1 : OWN0;
            gnt0_q <= ~next_idx;
            gnt1_q <= next_idx;
        end
    end

endmodule

// File: tb/tb_ahb_sram_arbiter.sv
// Bench for ahb_sram_arbiter: directed scenarios plus randomized traffic against a transaction-level arbiter model.
module tb_ahb_sram_arbiter;
    localparam int MAXB = 16;
    localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10, SEQ = 2'b11;

    logic HCLK = 1'b0;
    logic HRESET;
    always #5 HCLK = ~HCLK;

    ahb_sram_arbiter_if bus();
    ahb_sram_arbiter #(.MAX_INCR_BEATS(MAXB)) dut (.HCLK(HCLK), .HRESET(HRESET), .bus(bus));

    logic        req [2];
    logic        lck [2];
    logic        wr  [2];
    logic [1:0]  tr  [2];
    logic [2:0]  bu  [2];
    logic [2:0]  sz  [2];
    logic [31:0] ad  [2];
    logic [31:0] wd  [2];
    logic        rdy;
    logic        resp;

    assign bus.m0_HBUSREQ = req[0];  assign bus.m1_HBUSREQ = req[1];
    assign bus.m0_HLOCK   = lck[0];  assign bus.m1_HLOCK   = lck[1];
    assign bus.m0_HTRANS  = tr[0];   assign bus.m1_HTRANS  = tr[1];
    assign bus.m0_HADDR   = ad[0];   assign bus.m1_HADDR   = ad[1];
    assign bus.m0_HWRITE  = wr[0];   assign bus.m1_HWRITE  = wr[1];
    assign bus.m0_HSIZE   = sz[0];   assign bus.m1_HSIZE   = sz[1];
    assign bus.m0_HBURST  = bu[0];   assign bus.m1_HBURST  = bu[1];
    assign bus.m0_HWDATA  = wd[0];   assign bus.m1_HWDATA  = wd[1];
    assign bus.s_HREADY   = rdy;
    assign bus.s_HRESP    = resp;

    // Behavioural SRAM at 0x0010_0000, 16 words, zero wait states unless rdy is pulled low.
    logic [31:0] mem [16];
    logic        pv, pw;
    logic [3:0]  pa;
    logic [31:0] sram_rdata;
    assign sram_rdata = (pv && !pw) ? mem[pa] : 32'h0;
    assign bus.s_HRDATA = sram_rdata;

    always @(posedge HCLK) begin
        if (HRESET) begin
            pv <= 1'b0;
            pw <= 1'b0;
            pa <= 4'd0;
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
        end else if (rdy) begin
            if (pv && pw) mem[pa] <= bus.s_HWDATA;
            pv <= bus.s_HTRANS[1] && (bus.s_HADDR[31:20] == 12'h001);
            pw <= bus.s_HWRITE;
            pa <= bus.s_HADDR[5:2];
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference: who holds the grant, who owns the address and data phases, and how far the
    // current burst on the slave has progressed (beats issued since its NONSEQ).
    int m_g, m_hm, m_do, m_rr, m_done, m_len;
    bit m_lock;

    task automatic model_step();
        int  win;
        bit  hold;
        logic [1:0] trn;
        logic [2:0] brs;
        if (HRESET) begin
            m_g = 0; m_hm = 0; m_do = 0; m_rr = 1; m_lock = 0;
            m_done = 1;  // reset behaves like a burst that has just started
            m_len = 0;
        end else if (rdy) begin
            trn = tr[m_hm];
            brs = bu[m_hm];
            if (trn == NONSEQ) begin
                m_done = 1;
                m_len  = (brs >= 3'd2) ? (4 << ((int'(brs) - 2) / 2)) : 0;
            end else if (trn == SEQ) begin
                m_done++;
            end
            hold = (lck[m_g] && req[m_g]) || (m_hm != m_g) || (m_done < m_len)
                || (brs == 3'b001 && trn != IDLE && m_done < MAXB);
            win = m_g;
            if (!hold) begin
                if (req[m_rr])          win = m_rr;
                else if (req[1 - m_rr]) win = 1 - m_rr;
            end
            if (win != m_g) m_rr = 1 - win;
            m_do = m_hm;
            m_hm = m_g;
            m_lock = lck[m_g];
            m_g = win;
        end
    endtask

    task automatic compare_all();
        chk("gnt0",     32'(bus.m0_HGRANT), 32'(m_g == 0));
        chk("gnt1",     32'(bus.m1_HGRANT), 32'(m_g == 1));
        chk("hmaster",  32'(bus.HMASTER),   32'(m_hm));
        chk("mastlock", 32'(bus.HMASTLOCK), 32'(m_lock));
        chk("s_haddr",  bus.s_HADDR,        ad[m_hm]);
        chk("s_htrans", 32'(bus.s_HTRANS),  32'(tr[m_hm]));
        chk("s_hwrite", 32'(bus.s_HWRITE),  32'(wr[m_hm]));
        chk("s_hsize",  32'(bus.s_HSIZE),   32'(sz[m_hm]));
        chk("s_hburst", 32'(bus.s_HBURST),  32'(bu[m_hm]));
        chk("s_hwdata", bus.s_HWDATA,       wd[m_do]);
        chk("hready",   32'(bus.HREADY),    32'(rdy));
        chk("hresp",    32'(bus.HRESP),     32'(resp));
        chk("hrdata",   bus.HRDATA,         sram_rdata);
    endtask

    task automatic step();
        #1 compare_all();
        @(posedge HCLK);
        model_step();
        @(negedge HCLK);
    endtask

    task automatic idle_all();
        for (int m = 0; m < 2; m++) begin
            req[m] = 1'b0; lck[m] = 1'b0; wr[m] = 1'b0; tr[m] = IDLE; bu[m] = 3'b000;
            sz[m] = 3'b010; ad[m] = 32'h0010_0000; wd[m] = 32'h0;
        end
        rdy = 1'b1;
        resp = 1'b0;
    endtask

    task automatic setm(input int m, input logic r, input logic l, input logic [1:0] t,
                        input logic [2:0] b, input logic w, input logic [31:0] a, input logic [31:0] d);
        req[m] = r; lck[m] = l; tr[m] = t; bu[m] = b; wr[m] = w; ad[m] = a; wd[m] = d;
    endtask

    task automatic reset_dut();
        HRESET = 1'b1;
        step();
        step();
        HRESET = 1'b0;
    endtask

    logic exp_m1 [6];

    initial begin
        idle_all();
        tr[0] = NONSEQ;
        HRESET = 1'b1;
        @(posedge HCLK);
        model_step();
        @(negedge HCLK);
        step();
        step();
        chk("rst_gnt0",   32'(bus.m0_HGRANT), 32'd1);
        chk("rst_gnt1",   32'(bus.m1_HGRANT), 32'd0);
        chk("rst_hm",     32'(bus.HMASTER),   32'd0);
        chk("rst_htrans", 32'(bus.s_HTRANS),  32'(NONSEQ));
        HRESET = 1'b0;
        tr[0] = IDLE;

        // m1 alone: write word 4, read it back
        setm(1, 1'b1, 1'b0, NONSEQ, 3'b000, 1'b1, 32'h0010_0010, 32'hA5A5_0001);
        step();
        chk("m1_gnt_lat", 32'(bus.m1_HGRANT), 32'd1);
        chk("m1_hm_pre",  32'(bus.HMASTER),   32'd0);
        step();
        chk("m1_hmaster", 32'(bus.HMASTER), 32'd1);
        step();
        chk("m1_hwdata", bus.s_HWDATA, 32'hA5A5_0001);
        step();
        wr[1] = 1'b0;
        step();
        step();
        chk("sram_w4", bus.HRDATA, 32'hA5A5_0001);

        // m1 writes word 2, then reads it through a 3-cycle wait state with m0 requesting
        ad[1] = 32'h0010_0008; wd[1] = 32'h5A5A_0002; wr[1] = 1'b1;
        step();
        step();
        wr[1] = 1'b0;
        step();
        rdy = 1'b0; req[0] = 1'b1; wd[0] = 32'hDEAD_0000;
        for (int i = 0; i < 3; i++) step();
        rdy = 1'b1;
        chk("ws_hrdata", bus.HRDATA, 32'h5A5A_0002);
        chk("ws_hm",     32'(bus.HMASTER),   32'd1);
        chk("ws_gnt1",   32'(bus.m1_HGRANT), 32'd1);
        setm(1, 1'b0, 1'b0, IDLE, 3'b000, 1'b0, 32'h0010_0000, 32'h0);
        step();
        chk("ret_gnt0", 32'(bus.m0_HGRANT), 32'd1);
        step();
        step();

        // contention from reset with single transfers: grant alternates, m1 first
        idle_all();
        reset_dut();
        setm(0, 1'b1, 1'b0, NONSEQ, 3'b000, 1'b1, 32'h0010_0020, 32'h1111_0000);
        setm(1, 1'b1, 1'b0, NONSEQ, 3'b000, 1'b1, 32'h0010_0024, 32'h2222_0000);
        exp_m1 = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 6; k++) begin
            step();
            chk("cont_gnt1", 32'(bus.m1_HGRANT), 32'(exp_m1[k]));
        end

        // INCR4 by m0 while m1 requests
        idle_all();
        reset_dut();
        setm(0, 1'b1, 1'b0, NONSEQ, 3'b011, 1'b1, 32'h0010_0000, 32'hC0DE_0000);
        req[1] = 1'b1;
        for (int b = 0; b < 4; b++) begin
            tr[0] = (b == 0) ? NONSEQ : SEQ;
            ad[0] = 32'h0010_0000 + 32'(b * 4);
            step();
            chk("incr4_hm", 32'(bus.HMASTER), 32'd0);
            if (b < 3) chk("incr4_hold", 32'(bus.m1_HGRANT), 32'd0);
            else       chk("incr4_rel",  32'(bus.m1_HGRANT), 32'd1);
        end
        setm(0, 1'b0, 1'b0, IDLE, 3'b000, 1'b0, 32'h0010_0000, 32'h0);
        for (int i = 0; i < 3; i++) step();

        // locked sequence by m0 while m1 requests
        idle_all();
        reset_dut();
        setm(0, 1'b1, 1'b1, NONSEQ, 3'b000, 1'b0, 32'h0010_0004, 32'h0);
        req[1] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("lock_gnt0",  32'(bus.m0_HGRANT), 32'd1);
            chk("lock_mlock", 32'(bus.HMASTLOCK), 32'd1);
        end
        lck[0] = 1'b0;
        step();
        chk("unlock_gnt1", 32'(bus.m1_HGRANT), 32'd1);
        step();

        // undefined-length INCR by m0 is cut after MAXB beats when m1 requests
        idle_all();
        reset_dut();
        setm(0, 1'b1, 1'b0, NONSEQ, 3'b001, 1'b1, 32'h0010_0000, 32'h7777_0000);
        req[1] = 1'b1;
        for (int b = 1; b <= MAXB; b++) begin
            tr[0] = (b == 1) ? NONSEQ : SEQ;
            ad[0] = 32'h0010_0000 + 32'(((b - 1) % 16) * 4);
            step();
            if (b < MAXB) chk("incr_hold", 32'(bus.m1_HGRANT), 32'd0);
            else          chk("incr_cap",  32'(bus.m1_HGRANT), 32'd1);
        end
        setm(0, 1'b0, 1'b0, IDLE, 3'b001, 1'b0, 32'h0010_0000, 32'h0);
        for (int i = 0; i < 3; i++) step();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int m = 0; m < 2; m++) begin
                req[m] = ($urandom_range(3, 0) != 0);
                lck[m] = ($urandom_range(7, 0) == 0);
                tr[m]  = 2'($urandom_range(3, 0));
                bu[m]  = 3'($urandom_range(7, 0));
                sz[m]  = 3'($urandom_range(2, 0));
                wr[m]  = 1'($urandom_range(1, 0));
                ad[m]  = 32'h0010_0000 | (32'($urandom_range(15, 0)) << 2);
                wd[m]  = $urandom;
            end
            rdy    = ($urandom_range(4, 0) != 0);
            resp   = ($urandom_range(15, 0) == 0);
            HRESET = ($urandom_range(199, 0) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
